// File: rtl/word_rx_pkg.sv
// rtl/word_rx_pkg.sv - shared UART defines: default timing and receiver state encoding
// Purpose: constants and types shared by the UART receiver and transmitter side.
// Ports: none (package).
package word_rx_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int DEFAULT_CLK_PER_BIT  = 434;
  // Idle bit-times tolerated between bytes of one word
  localparam int DEFAULT_TIMEOUT_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Counter width able to hold 0..v-1, never narrower than one bit
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_byte_rx_module.sv
// rtl/uart_byte_rx_module.sv - single-byte 8N1 UART receiver with stop-bit strobes
// Purpose: synchronizes the line, detects a start bit, samples 8 data bits LSB first
//          at mid-bit and checks the stop bit.
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_rx        asynchronous UART line, idle high
//   o_byte      received byte, valid while o_byte_done is high
//   o_byte_done strobe in the stop-sample cycle when the stop bit is high
//   o_frame_err strobe in the stop-sample cycle when the stop bit is low
//   o_busy      receiver state is not IDLE
module uart_byte_rx_module
  import word_rx_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int            TW      = cnt_width(CLK_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLK_PER_BIT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_rx_prev;
  logic [2:0]      r_arm;
  rx_state_t       r_state;
  rx_state_t       w_next_state;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;

  logic            w_rx;
  logic            w_fall;
  logic            w_mid_start;
  logic            w_bit_end;
  logic            w_stop_tick;

  // Synchronizer and edge-detect history. r_arm blocks edge detection until the
  // pipeline holds real line samples, so a line that is low when reset releases
  // is not mistaken for a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_arm     <= 3'b000;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_arm     <= {r_arm[1:0], 1'b1};
    end
  end

  assign w_rx        = r_sync2;
  assign w_fall      = r_arm[2] & r_rx_prev & ~w_rx;
  assign w_mid_start = (r_timer == HALF_M1);
  assign w_bit_end   = (r_timer == FULL_M1);
  assign w_stop_tick = (r_state == ST_STOP) && w_bit_end;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall) w_next_state = ST_START;
      ST_START: if (w_mid_start) w_next_state = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = ST_STOP;
      ST_STOP:  if (w_bit_end) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state <= w_next_state;
      // Timer restarts on every state change and every DATA bit boundary, so
      // from mid start bit each later sample lands at mid-bit.
      if ((r_state == ST_IDLE) || (w_next_state != r_state) || w_bit_end)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
      if (r_state == ST_START)
        r_bit_idx <= 3'd0;
      if ((r_state == ST_DATA) && w_bit_end) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign o_byte      = r_shift;
  assign o_byte_done = w_stop_tick & w_rx;
  assign o_frame_err = w_stop_tick & ~w_rx;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: rtl/word_rx_module.sv
// rtl/word_rx_module.sv - assembles three UART bytes MSB first into a 24-bit word
// Purpose: byte index, word assembly, inter-byte timeout and output strobes on top
//          of uart_byte_rx_module.
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   RX_Pin_In  asynchronous UART line, idle high, 8N1, LSB first
//   Word       last complete received word
//   Word_Valid one-cycle pulse, Word updated in the same cycle
//   Frame_Err  one-cycle pulse after a bad stop bit
//   Busy       receiver active or a partial word is held
module word_rx_module
  import word_rx_pkg::*;
#(
  parameter int CLK_PER_BIT  = DEFAULT_CLK_PER_BIT,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_Pin_In,
  output logic [23:0] Word,
  output logic        Word_Valid,
  output logic        Frame_Err,
  output logic        Busy
);

  localparam int             TO_CLKS = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int             TOW     = cnt_width(TO_CLKS);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CLKS - 1);

  logic [7:0]     w_byte;
  logic           w_byte_done;
  logic           w_frame_err;
  logic           w_rx_busy;
  logic           w_idle_partial;

  logic [1:0]     r_index;
  // Bytes 0 and 1 of the word; byte 2 goes straight from the receiver into Word.
  logic [15:0]    r_asm;
  logic [23:0]    r_word;
  logic           r_word_valid;
  logic           r_frame_err;
  logic [TOW-1:0] r_timeout;

  uart_byte_rx_module #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_byte_rx (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_rx        (RX_Pin_In),
    .o_byte      (w_byte),
    .o_byte_done (w_byte_done),
    .o_frame_err (w_frame_err),
    .o_busy      (w_rx_busy)
  );

  assign w_idle_partial = ~w_rx_busy && (r_index != 2'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_index      <= 2'd0;
      r_asm        <= 16'h0000;
      r_word       <= 24'h000000;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_timeout    <= '0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_frame_err) begin
        r_index     <= 2'd0;
        r_asm       <= 16'h0000;
        r_frame_err <= 1'b1;
        r_timeout   <= '0;
      end else if (w_byte_done) begin
        r_timeout <= '0;
        case (r_index)
          2'd0: begin
            r_asm[15:8] <= w_byte;
            r_index     <= 2'd1;
          end
          2'd1: begin
            r_asm[7:0] <= w_byte;
            r_index    <= 2'd2;
          end
          default: begin
            r_word       <= {r_asm, w_byte};
            r_word_valid <= 1'b1;
            r_index      <= 2'd0;
            r_asm        <= 16'h0000;
          end
        endcase
      end else if (w_idle_partial) begin
        // Silent discard once the line has idled a full timeout with a partial word
        if (r_timeout == TO_LAST) begin
          r_index   <= 2'd0;
          r_asm     <= 16'h0000;
          r_timeout <= '0;
        end else begin
          r_timeout <= r_timeout + 1'b1;
        end
      end else begin
        r_timeout <= '0;
      end
    end
  end

  assign Word       = r_word;
  assign Word_Valid = r_word_valid;
  assign Frame_Err  = r_frame_err;
  assign Busy       = w_rx_busy | (r_index != 2'd0);

endmodule

// File: tb/tb_word_rx_module.sv
// tb/tb_word_rx_module.sv - self-checking bench for word_rx_module
module tb_word_rx_module;

  localparam int CPB = 16;
  localparam int TOB = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RX_Pin_In = 1'b1;
  logic [23:0] Word;
  logic        Word_Valid;
  logic        Frame_Err;
  logic        Busy;

  always #5 CLK = ~CLK;

  word_rx_module #(
    .CLK_PER_BIT  (CPB),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_Pin_In  (RX_Pin_In),
    .Word       (Word),
    .Word_Valid (Word_Valid),
    .Frame_Err  (Frame_Err),
    .Busy       (Busy)
  );

  int          checks = 0;
  int          failures = 0;

  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  int          obs_ferr = 0;
  int          both_cnt = 0;
  int          hold_viol = 0;
  logic [23:0] prev_word = 24'h0;

  int          m_index = 0;
  logic [23:0] m_part = 24'h0;
  int          exp_ferr = 0;
  int          m_idle_clks = 0;
  bit          m_last_bad = 0;

  always @(negedge CLK) begin
    if (Word_Valid) obs_q.push_back(Word);
    if (Frame_Err) obs_ferr++;
    if (Word_Valid && Frame_Err) both_cnt++;
    if (!RST && !Word_Valid && (Word !== prev_word)) hold_viol++;
    prev_word = Word;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic line_idle(input int bits);
    RX_Pin_In = 1'b1;
    tick(bits * CPB);
    m_idle_clks += bits * CPB;
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit stop_ok);
    RX_Pin_In = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX_Pin_In = b[i];
      tick(CPB);
    end
    RX_Pin_In = stop_ok;
    tick(CPB);
    RX_Pin_In = 1'b1;
  endtask

  // Reference: bytes fill the word MSB first; a bad stop or a long idle gap with a
  // partial word drops it. Idle time in the receiver starts half a stop bit early.
  task automatic send(input logic [7:0] b, input bit ok);
    if (m_last_bad) line_idle(1);
    if ((m_index != 0) && (m_idle_clks + CPB / 2 >= TOB * CPB)) m_index = 0;
    if (!ok) begin
      exp_ferr++;
      m_index = 0;
    end else begin
      m_part[23 - 8 * m_index -: 8] = b;
      if (m_index == 2) begin
        exp_q.push_back(m_part);
        m_index = 0;
      end else begin
        m_index++;
      end
    end
    m_last_bad  = !ok;
    m_idle_clks = 0;
    tx_frame(b, ok);
  endtask

  task automatic verify(input string tag);
    tick(4);
    check({tag, "_word_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_word"}, obs_q[i], exp_q[i]);
    check({tag, "_frame_err_count"}, obs_ferr, exp_ferr);
    obs_q.delete();
    exp_q.delete();
    obs_ferr = 0;
    exp_ferr = 0;
  endtask

  initial begin
    int gaps[6];
    gaps = '{0, 0, 1, 2, 9, 12};

    RST = 1'b1;
    tick(3);
    check("reset_word", Word, 24'h000000);
    check("reset_valid", Word_Valid, 1'b0);
    check("reset_ferr", Frame_Err, 1'b0);
    check("reset_busy", Busy, 1'b0);
    RST = 1'b0;
    tick(2);

    send(8'h12, 1); send(8'h34, 1); send(8'h56, 1);
    verify("back_to_back");

    RX_Pin_In = 1'b0;
    tick(CPB / 4);
    RX_Pin_In = 1'b1;
    tick(CPB);
    m_idle_clks = 0;
    check("glitch_busy", Busy, 1'b0);
    verify("glitch");

    send(8'h11, 1); send(8'h22, 0);
    send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1);
    verify("frame_err");

    send(8'h01, 1); send(8'h02, 1);
    line_idle(1);
    check("partial_busy", Busy, 1'b1);
    line_idle(11);
    check("timeout_busy", Busy, 1'b0);
    send(8'h0A, 1); send(8'h0B, 1); send(8'h0C, 1);
    verify("timeout");

    send(8'h05, 1);
    line_idle(9);
    send(8'h06, 1); send(8'h07, 1);
    verify("gap_below_timeout");

    send(8'h12, 1);
    RX_Pin_In = 1'b0;
    tick(5 * CPB + CPB / 2);
    RST = 1'b1;
    tick(3);
    check("mid_reset_word", Word, 24'h000000);
    check("mid_reset_busy", Busy, 1'b0);
    RST = 1'b0;
    m_index = 0;
    tick(2 * CPB);
    RX_Pin_In = 1'b1;
    tick(2 * CPB);
    m_idle_clks = 0;
    check("after_reset_word", Word, 24'h000000);
    send(8'h00, 1); send(8'h00, 1); send(8'h0D, 1);
    verify("reset_recover");

    for (int k = 1; k <= 10; k++) begin
      send(8'h00, 1); send(8'h00, 1); send(8'(k), 1);
    end
    verify("ten_words");

    for (int n = 0; n < 30; n++) begin
      int g;
      g = gaps[$urandom_range(0, 5)];
      if (g > 0) line_idle(g);
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0));
    end
    line_idle(1);
    verify("random");

    check("valid_and_ferr_together", both_cnt, 0);
    check("word_hold", hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_rx_module.md
WORD_RX_MODULE -- requirements
Module: word_rx_module

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 434, meaning clocks per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 10, meaning idle bit-times allowed between bytes of one word.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RX_Pin_In  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 SHALL have port Word  output  24  last complete received word.
REQ-007 SHALL have port Word_Valid  output  1  one-cycle pulse; Word updated in the same cycle.
REQ-008 SHALL have port Frame_Err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port Busy  output  1  high whenever the state is not IDLE or a partial word is held.

Function
REQ-010 SHALL pass RX_Pin_In through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 IDLE: a synchronized high-to-low transition SHALL enter START and clear the bit-timer.
REQ-013 START: at timer = CLK_PER_BIT/2 - 1 (mid start bit), a low line SHALL enter DATA; a high line (glitch) SHALL return to IDLE with no other effect.
REQ-014 DATA: SHALL sample one bit every CLK_PER_BIT clocks at mid-bit, 8 bits, shifted LSB first; after bit 7 SHALL enter STOP.
REQ-015 STOP: SHALL sample at mid stop bit, then return to IDLE in the next cycle, so a back-to-back start bit is detected.
REQ-016 A high stop bit SHALL store the byte at the current index: index 0 -> bits [23:16], 1 -> [15:8], 2 -> [7:0].
REQ-017 On the good byte at index 2, SHALL load Word from the assembly register and pulse Word_Valid in the cycle after the stop sample, then reset index to 0.
REQ-018 A low stop bit SHALL pulse Frame_Err in the cycle after the sample, discard the byte and any partial word, and reset index to 0.
REQ-019 With index != 0 and state IDLE for TIMEOUT_BITS*CLK_PER_BIT consecutive clocks, SHALL discard the partial word and reset index to 0, with no output pulse.
REQ-020 Word SHALL hold its value between Word_Valid pulses; Word_Valid and Frame_Err SHALL never assert in the same cycle.
REQ-021 Bit-timer width SHALL be sized from CLK_PER_BIT; timeout counter width from TIMEOUT_BITS*CLK_PER_BIT; neither SHALL wrap within its range.

Reset
REQ-022 RST high at a rising edge SHALL force IDLE, index 0, assembly register 0, Word = 24'h000000, Word_Valid = 0, Frame_Err = 0, Busy = 0, all timers 0.
REQ-023 RST asserted mid-byte SHALL abandon the byte with no pulse; after release, the first byte is recognized only from a fresh falling edge.
REQ-024 Synchronizer flops SHALL reset to 1 (idle line).

Structure
REQ-025 State encodings, the default CLK_PER_BIT and the default TIMEOUT_BITS SHALL live in the shared UART defines file, used with the transmitter side.
REQ-026 The single-byte receiver (synchronizer, START/DATA/STOP, byte-done and frame-error strobes) SHALL be the sub-module uart_byte_rx_module; word_rx_module SHALL add the byte index, assembly, timeout and outputs.

Verification
REQ-027 Bytes 0x12, 0x34, 0x56 back-to-back -> one Word_Valid pulse with Word = 0x123456; no Frame_Err.
REQ-028 Line low for CLK_PER_BIT/4 clocks, then high -> return to IDLE, no pulses, Busy low again within 1 bit-time.
REQ-029 Bytes 0x11, then 0x22 with stop bit forced low -> Frame_Err pulse, no Word_Valid; then 0xAA, 0xBB, 0xCC -> Word = 0xAABBCC.
REQ-030 Bytes 0x01, 0x02, 12 idle bit-times, then 0x0A, 0x0B, 0x0C -> a single Word_Valid with Word = 0x0A0B0C.
REQ-031 RST pulsed during bit 4 of the second byte, then 0x00, 0x00, 0x0D -> Word = 0x00000D; Word read 0x000000 right after reset.
REQ-032 Ten consecutive words 0x000001..0x00000A -> ten Word_Valid pulses with Word matching each value in order.
